// File: rtl/moore_seq_pkg.sv
// Shared definitions for the 1011 Moore sequence detector.
//
// Contents:
//   state_e         - FSM state encoding. Each state is named by the suffix of
//                     the input stream matched so far (S0 = nothing matched,
//                     S4 = "1011" just completed).
//   PATTERN         - the detected bit pattern, oldest bit in the MSB. This is
//                     a reference constant for models outside the design.
//   seq_next_state  - the transition function, kept here so that the RTL and
//                     any reference model share a single definition.
package moore_seq_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011" - detect state
    } state_e;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Overlapping transitions. After a detect (S4) the trailing "1" is kept,
    // so S4 behaves like S1 for the next bit.
    // Illegal encodings (5..7) fall back to S0 whatever d_in is.
    function automatic state_e seq_next_state(input state_e cur, input logic bit_in);
        state_e nxt;
        case (cur)
            S0:      nxt = bit_in ? S1 : S0;
            S1:      nxt = bit_in ? S1 : S2;
            S2:      nxt = bit_in ? S3 : S0;
            S3:      nxt = bit_in ? S4 : S2;
            S4:      nxt = bit_in ? S1 : S2;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/moore_overlapping_seq_detector.sv
// Moore-type overlapping detector for the serial pattern 1011.
//
// Takes one bit of d_in per rising clock edge. It raises d_out for one cycle
// in the cycle after the bit that completes "1011". Overlap is allowed: the
// final "1" of a match can start the next one.
// A saturating counter records the number of completed matches for
// debug and status.
//
// Parameters:
//   CNT_W      - width of match_cnt (default 8).
//
// Ports:
//   clk        - single clock, all state updates on the rising edge.
//   rst        - synchronous active-low reset, sampled on the rising edge.
//   d_in       - serial data bit, ignored while rst is low.
//   d_out      - high while the FSM is in S4 (pattern just completed),
//                driven straight from a flop.
//   match_cnt  - number of completed matches. It sticks at all-ones.
module moore_overlapping_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    output logic             d_out,
    output logic [CNT_W-1:0] match_cnt
);

    state_e           state_q, state_d;
    logic             d_out_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_sat;

    // Next-state decode. Illegal encodings go back to S0 through the
    // default branch in seq_next_state.
    always_comb begin
        state_d = seq_next_state(state_q, d_in);
    end

    // d_out_q is loaded from the next-state decode, so it always equals
    // (state_q == S4). Taking d_out from a flop keeps it free of decode glitches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
            d_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_out_q <= (state_d == S4);
        end
    end

    // Match counter: counts up on each edge that enters S4, and stops at all-ones.
    assign cnt_sat = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S4) && !cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign d_out     = d_out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_overlapping_seq_detector.sv
// Directed testbench for moore_overlapping_seq_detector. Expected values
// are worked out by hand.
// Two instances share the same stimulus: the default CNT_W=8 instance, and
// a CNT_W=2 instance used to test counter saturation.
module tb_moore_overlapping_seq_detector;
    import moore_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       d_in;
    logic       d_out;
    logic [7:0] match_cnt;
    logic       d_out_s;
    logic [1:0] match_cnt_s;

    int n_checks = 0;
    int n_bad    = 0;
    int pulses_s = 0;

    moore_overlapping_seq_detector #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_out     (d_out),
        .match_cnt (match_cnt)
    );

    moore_overlapping_seq_detector #(.CNT_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_out     (d_out_s),
        .match_cnt (match_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, clock it in, and sample 1 time unit after the edge.
    // Also counts pulses on the small instance.
    task automatic step(input logic b);
        d_in = b;
        @(posedge clk);
        #1;
        if (d_out_s === 1'b1) pulses_s++;
    endtask

    // Hold reset low for two edges while d_in toggles.
    task automatic do_reset();
        rst = 1'b0;
        step(1'b1);
        step(1'b0);
        rst = 1'b1;
        pulses_s = 0;
    endtask

    // Feed a stream from a clean reset. Checks d_out after every bit against
    // the 1-based positions of the completing bits, then checks match_cnt.
    task automatic run_seq(input string tag, input logic bits[$], input int hits[$]);
        logic exp;
        for (int i = 0; i < bits.size(); i++) begin
            step(bits[i]);
            exp = 1'b0;
            foreach (hits[k]) if (hits[k] == i + 1) exp = 1'b1;
            check_eq($sformatf("%s_dout_bit%0d", tag, i + 1), 32'(d_out), 32'(exp));
        end
        check_eq({tag, "_cnt"}, 32'(match_cnt), 32'(hits.size()));
    endtask

    logic   seq[$];
    int     hits[$];
    state_e st_exp[$];

    initial begin
        rst  = 1'b0;
        d_in = 1'b0;
        #2;

        // Reset state
        do_reset();
        check_eq("rst_dout", 32'(d_out), 32'd0);
        check_eq("rst_cnt", 32'(match_cnt), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(S0));
        check_eq("rst_cnt_s", 32'(match_cnt_s), 32'd0);

        // Basic and overlapping stream
        seq  = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        hits = '{7, 11, 14};
        run_seq("basic", seq, hits);

        // Chain of overlapping matches
        do_reset();
        seq  = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        hits = '{4, 7, 10};
        run_seq("chain", seq, hits);

        // Near misses, with the state checked after every bit
        do_reset();
        seq    = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0};
        st_exp = '{S1, S2, S0, S1, S1, S1, S2, S3, S2, S0};
        for (int i = 0; i < seq.size(); i++) begin
            step(seq[i]);
            check_eq($sformatf("near_state_bit%0d", i + 1), 32'(dut.state_q), 32'(st_exp[i]));
            check_eq($sformatf("near_dout_bit%0d", i + 1), 32'(d_out), 32'd0);
        end
        check_eq("near_cnt", 32'(match_cnt), 32'd0);

        // Reset in the middle of a pattern
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check_eq("mid_pre_state", 32'(dut.state_q), 32'(S3));
        rst = 1'b0;
        step(1'b1);
        rst = 1'b1;
        check_eq("mid_rst_state", 32'(dut.state_q), 32'(S0));
        check_eq("mid_rst_dout", 32'(d_out), 32'd0);
        step(1'b1);
        check_eq("mid_after_dout", 32'(d_out), 32'd0);
        check_eq("mid_after_state", 32'(dut.state_q), 32'(S1));
        step(1'b0);
        step(1'b1);
        check_eq("mid_s3_dout", 32'(d_out), 32'd0);
        step(1'b1);
        check_eq("mid_hit_dout", 32'(d_out), 32'd1);
        check_eq("mid_hit_cnt", 32'(match_cnt), 32'd1);
        step(1'b0);
        check_eq("mid_post_dout", 32'(d_out), 32'd0);

        // Saturation: five matches, so the 2-bit counter must stop at 3
        do_reset();
        seq  = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        hits = '{4, 7, 10, 13, 16};
        run_seq("sat", seq, hits);
        check_eq("sat_pulses_s", 32'(pulses_s), 32'd5);
        check_eq("sat_cnt_s", 32'(match_cnt_s), 32'd3);
        step(1'b0);
        check_eq("sat_hold_cnt_s", 32'(match_cnt_s), 32'd3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
